// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: holds cpu_reset, then supervises the run until self-loop halt or timeout.
// All outputs are registered or decoded from the registered state; there is no backpressure (retirements are sampled every cycle).
module cpu_run_ctrl #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int HOLD_CYCLES = 100,
    parameter int LOOP_LIMIT  = 4,
    parameter int TIMEOUT     = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             retire_valid,
    input  logic [PC_W-1:0]  retire_pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic [1:0]       done_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOOP_LIMIT + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0]    LOOP_LAST = LW'(LOOP_LIMIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HW-1:0]     r_hold_cnt;
    logic [LW-1:0]     r_loop_cnt;
    logic              r_last_valid;
    logic [PC_W-1:0]   r_last_pc;
    logic [1:0]        r_done_code;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_instr_cnt;

    logic w_retire;
    logic w_match;
    logic w_halt;
    logic w_timeout;

    always_comb begin
        w_retire  = (r_state == S_RUN) && retire_valid;
        w_match   = w_retire && r_last_valid && (retire_pc == r_last_pc);
        w_halt    = w_match && (r_loop_cnt == LOOP_LAST);
        w_timeout = TO_EN && (r_state == S_RUN) && (r_cycle_cnt == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt is tested before timeout so a self-loop in the final cycle reports as a halt.
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = S_HOLD;
        end else begin
            case (r_state)
                S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_halt)         w_state_nxt = S_HALTED;
                    else if (w_timeout) w_state_nxt = S_TIMEOUT;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        cpu_reset = 1'b0;
        running   = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_HOLD:    cpu_reset = 1'b1;
            S_RUN:     running   = 1'b1;
            default:   done      = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_hold_cnt   <= '0;
            r_loop_cnt   <= '0;
            r_last_valid <= 1'b0;
            r_done_code  <= 2'b00;
            r_cycle_cnt  <= '0;
            r_instr_cnt  <= '0;
        end else begin
            case (r_state)
                S_HOLD: r_hold_cnt <= r_hold_cnt + HW'(1);
                S_RUN: begin
                    if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                    if (w_retire) begin
                        if (r_instr_cnt != '1) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                        r_loop_cnt   <= w_match ? (r_loop_cnt + LW'(1)) : '0;
                        r_last_valid <= 1'b1;
                    end
                    if (w_halt)         r_done_code <= 2'b01;
                    else if (w_timeout) r_done_code <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    // No reset needed: the PC is only compared while r_last_valid is set.
    always_ff @(posedge clk) begin
        if (w_retire) r_last_pc <= retire_pc;
    end

    assign done_code = r_done_code;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with HOLD_CYCLES=4, LOOP_LIMIT=3, TIMEOUT=20.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic        cpu_reset, running, done;
    logic [1:0]  done_code;
    logic [31:0] cycle_cnt, instr_cnt;

    int checks = 0;
    int errors = 0;

    cpu_run_ctrl #(
        .PC_W(32), .CNT_W(32), .HOLD_CYCLES(4), .LOOP_LIMIT(3), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .cpu_reset(cpu_reset), .running(running), .done(done),
        .done_code(done_code), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for two cycles, then step through the four HOLD cycles; returns in the first RUN cycle.
    task automatic start_run();
        reset = 1'b1; restart = 1'b0; retire_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; restart = 1'b0; retire_valid = 1'b0;
        tick(); tick();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %0b exp 1", cpu_reset); end
        checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_flags got run=%0b done=%0b exp 0/0", running, done); end
        checks++; if (done_code !== 2'b00) begin errors++; $display("FAIL rst_done_code got %0b exp 00", done_code); end
        checks++; if (cycle_cnt !== 0 || instr_cnt !== 0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", cycle_cnt, instr_cnt); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cpu_reset !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL hold_%0d got cpu_reset=%0b running=%0b exp 1/0", i, cpu_reset, running); end
            tick();
        end
        checks++; if (cpu_reset !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL run_entry got cpu_reset=%0b running=%0b exp 0/1", cpu_reset, running); end
        checks++; if (cycle_cnt !== 0) begin errors++; $display("FAIL run_cycle_0 got %0d exp 0", cycle_cnt); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (cycle_cnt !== k) begin errors++; $display("FAIL run_cycle_%0d got %0d exp %0d", k, cycle_cnt, k); end
        end
    endtask

    task automatic test_halt();
        logic [31:0] pcs [6];
        pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008};
        start_run();
        retire_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            retire_pc = pcs[i];
            tick();
            if (i == 4) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_early got done=%0b exp 0", done); end
            end
        end
        checks++; if (done !== 1'b1 || running !== 1'b0 || cpu_reset !== 1'b0) begin errors++; $display("FAIL halt_flags got done=%0b run=%0b cpu_reset=%0b exp 1/0/0", done, running, cpu_reset); end
        checks++; if (done_code !== 2'b01) begin errors++; $display("FAIL halt_code got %0b exp 01", done_code); end
        checks++; if (instr_cnt !== 6) begin errors++; $display("FAIL halt_instr got %0d exp 6", instr_cnt); end
        retire_pc = 32'h4000;
        repeat (3) tick();
        retire_valid = 1'b0;
        checks++; if (instr_cnt !== 6) begin errors++; $display("FAIL halt_instr_frozen got %0d exp 6", instr_cnt); end
        checks++; if (cycle_cnt !== 6) begin errors++; $display("FAIL halt_cycle_frozen got %0d exp 6", cycle_cnt); end
        checks++; if (done_code !== 2'b01 || done !== 1'b1) begin errors++; $display("FAIL halt_sticky got code=%0b done=%0b exp 01/1", done_code, done); end
    endtask

    // Entered while HALTED at PC 0x3008 from test_halt.
    task automatic test_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (done !== 1'b0 || done_code !== 2'b00) begin errors++; $display("FAIL rs_done got done=%0b code=%0b exp 0/00", done, done_code); end
        checks++; if (cycle_cnt !== 0 || instr_cnt !== 0) begin errors++; $display("FAIL rs_counters got %0d/%0d exp 0/0", cycle_cnt, instr_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rs_hold_%0d got cpu_reset=%0b exp 1", i, cpu_reset); end
            tick();
        end
        checks++; if (running !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL rs_run got running=%0b cpu_reset=%0b exp 1/0", running, cpu_reset); end
        retire_valid = 1'b1; retire_pc = 32'h3008;
        repeat (3) tick();
        checks++; if (done !== 1'b0 || instr_cnt !== 3) begin errors++; $display("FAIL rs_stale_pc got done=%0b instr=%0d exp 0/3", done, instr_cnt); end
        tick();
        retire_valid = 1'b0;
        checks++; if (done !== 1'b1 || done_code !== 2'b01 || instr_cnt !== 4) begin errors++; $display("FAIL rs_halt got done=%0b code=%0b instr=%0d exp 1/01/4", done, done_code, instr_cnt); end
    endtask

    task automatic test_timeout();
        start_run();
        repeat (19) tick();
        checks++; if (done !== 1'b0 || running !== 1'b1 || cycle_cnt !== 19) begin errors++; $display("FAIL to_pre got done=%0b run=%0b cyc=%0d exp 0/1/19", done, running, cycle_cnt); end
        tick();
        checks++; if (done !== 1'b1 || done_code !== 2'b10) begin errors++; $display("FAIL to_code got done=%0b code=%0b exp 1/10", done, done_code); end
        checks++; if (cycle_cnt !== 20) begin errors++; $display("FAIL to_cycle got %0d exp 20", cycle_cnt); end
        retire_valid = 1'b1; retire_pc = 32'h7000;
        repeat (3) tick();
        retire_valid = 1'b0;
        checks++; if (cycle_cnt !== 20 || instr_cnt !== 0 || done_code !== 2'b10) begin errors++; $display("FAIL to_frozen got cyc=%0d instr=%0d code=%0b exp 20/0/10", cycle_cnt, instr_cnt, done_code); end
    endtask

    // Retirements in RUN cycles 17..20; the third repeat coincides with the timeout cycle.
    task automatic test_halt_vs_timeout();
        start_run();
        repeat (16) tick();
        retire_valid = 1'b1; retire_pc = 32'h5000;
        repeat (3) tick();
        checks++; if (done !== 1'b0 || cycle_cnt !== 19) begin errors++; $display("FAIL hvt_pre got done=%0b cyc=%0d exp 0/19", done, cycle_cnt); end
        tick();
        retire_valid = 1'b0;
        checks++; if (done !== 1'b1 || done_code !== 2'b01) begin errors++; $display("FAIL hvt_code got done=%0b code=%0b exp 1/01", done, done_code); end
        checks++; if (cycle_cnt !== 20 || instr_cnt !== 4) begin errors++; $display("FAIL hvt_counts got cyc=%0d instr=%0d exp 20/4", cycle_cnt, instr_cnt); end
    endtask

    task automatic test_reset_restart();
        start_run();
        retire_valid = 1'b1; retire_pc = 32'h6000;
        repeat (2) tick();
        checks++; if (instr_cnt !== 2) begin errors++; $display("FAIL rr_pre_instr got %0d exp 2", instr_cnt); end
        reset = 1'b1; restart = 1'b1;
        tick();
        checks++; if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rr_flags got cpu_reset=%0b run=%0b done=%0b exp 1/0/0", cpu_reset, running, done); end
        checks++; if (done_code !== 2'b00 || cycle_cnt !== 0 || instr_cnt !== 0) begin errors++; $display("FAIL rr_clear got code=%0b cyc=%0d instr=%0d exp 00/0/0", done_code, cycle_cnt, instr_cnt); end
        reset = 1'b0; restart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cpu_reset !== 1'b1 || instr_cnt !== 0 || done !== 1'b0) begin errors++; $display("FAIL rr_hold_%0d got cpu_reset=%0b instr=%0d done=%0b exp 1/0/0", i, cpu_reset, instr_cnt, done); end
            tick();
        end
        checks++; if (running !== 1'b1 || instr_cnt !== 0) begin errors++; $display("FAIL rr_run got running=%0b instr=%0d exp 1/0", running, instr_cnt); end
        repeat (3) tick();
        retire_valid = 1'b0;
        checks++; if (instr_cnt !== 3 || done !== 1'b0) begin errors++; $display("FAIL rr_after got instr=%0d done=%0b exp 3/0", instr_cnt, done); end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_restart();
        test_timeout();
        test_halt_vs_timeout();
        test_reset_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL provide parameter PC_W, default 32, meaning the width of the retired PC.
REQ-002 The block SHALL provide parameter CNT_W, default 32, meaning the width of the cycle and instruction counters.
REQ-003 The block SHALL provide parameter HOLD_CYCLES, default 100, meaning the number of cycles cpu_reset is held after reset or restart (legal range >=1).
REQ-004 The block SHALL provide parameter LOOP_LIMIT, default 4, meaning the number of consecutive same-PC retirements that signal a halt (legal range >=1).
REQ-005 The block SHALL provide parameter TIMEOUT, default 1000000, meaning the maximum number of RUN cycles; 0 disables the timeout.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port restart, input, 1 bit: a synchronous pulse that re-enters HOLD.
REQ-009 The block SHALL have port retire_valid, input, 1 bit: the CPU retired one instruction this cycle.
REQ-010 The block SHALL have port retire_pc, input, PC_W bits: the PC of the retired instruction, qualified by retire_valid.
REQ-011 The block SHALL have port cpu_reset, output, 1 bit: reset driven to the CPU under test.
REQ-012 The block SHALL have port running, output, 1 bit: high in RUN.
REQ-013 The block SHALL have port done, output, 1 bit: high in HALTED or TIMEOUT.
REQ-014 The block SHALL have port done_code, output, 2 bits: 00 none, 01 halt by self-loop, 10 timeout.
REQ-015 The block SHALL have port cycle_cnt, output, CNT_W bits: the number of RUN cycles.
REQ-016 The block SHALL have port instr_cnt, output, CNT_W bits: the number of retirements in RUN.

Function
REQ-017 The block SHALL implement the FSM states HOLD, RUN, HALTED and TIMEOUT; all outputs SHALL be registered or decoded from registered state only.
REQ-018 In HOLD the block SHALL drive cpu_reset=1, running=0 and done=0, increment the hold counter every cycle, and move to RUN after exactly HOLD_CYCLES HOLD cycles.
REQ-019 In RUN the block SHALL drive cpu_reset=0 and running=1, and increment cycle_cnt by 1 every cycle, saturating at all-ones.
REQ-020 In RUN, on each retire_valid, the block SHALL increment instr_cnt by 1, saturating at all-ones.
REQ-021 For loop detection on RUN retirements, if last_valid is set and retire_pc==last_pc the block SHALL increment loop_cnt, otherwise clear loop_cnt to 0; in both cases it SHALL set last_pc<=retire_pc and last_valid<=1.
REQ-022 A matching retirement that occurs while loop_cnt==LOOP_LIMIT-1 SHALL move the FSM to HALTED with done_code=01; that retirement SHALL be counted.
REQ-023 If TIMEOUT!=0 and a RUN cycle begins with cycle_cnt==TIMEOUT-1, the block SHALL move to TIMEOUT with done_code=10, and cycle_cnt SHALL end equal to TIMEOUT.
REQ-024 If the halt and timeout conditions occur in the same cycle, halt SHALL win: the block SHALL enter HALTED with done_code=01.
REQ-025 In HALTED and TIMEOUT the block SHALL drive done=1, running=0 and cpu_reset=0, freeze cycle_cnt, instr_cnt and done_code, and ignore retire_valid.
REQ-026 In HOLD, retire_valid SHALL be ignored: counters, last_pc and loop_cnt SHALL NOT change.
REQ-027 restart=1 in any state SHALL, at the next edge, enter HOLD with the hold counter, cycle_cnt, instr_cnt, loop_cnt, last_valid and done_code all cleared to 0.
REQ-028 restart=1 during HOLD SHALL restart the full HOLD_CYCLES hold period.
REQ-029 The last_pc register SHALL have no reset requirement, since it is qualified by last_valid.

Reset
REQ-030 reset=1 SHALL, at the next clk edge, set state=HOLD, cpu_reset=1, running=0, done=0, done_code=00, cycle_cnt=0, instr_cnt=0, loop_cnt=0, last_valid=0 and hold counter=0.
REQ-031 reset SHALL have priority over restart and over all FSM transitions.
REQ-032 reset asserted mid-RUN SHALL abandon the run with no done pulse.
REQ-033 After reset deasserts, cpu_reset SHALL remain 1 for exactly HOLD_CYCLES further cycles.

Verification (HOLD_CYCLES=4, LOOP_LIMIT=3, TIMEOUT=20)
REQ-034 Bench SHALL check: reset high 2 cycles, then low -> cpu_reset=1 for 4 cycles, then cpu_reset=0 and running=1, with cycle_cnt counting 1,2,3...
REQ-035 Bench SHALL check: retire PCs 0x3000, 0x3004, 0x3008, 0x3008, 0x3008, 0x3008 on consecutive cycles -> HALTED after the 6th retirement, with done=1, done_code=01 and instr_cnt=6; further retire_valid leaves instr_cnt at 6.
REQ-036 Bench SHALL check: no retirements in RUN -> after 20 RUN cycles done=1, done_code=10 and cycle_cnt=20, frozen thereafter.
REQ-037 Bench SHALL check: the 3rd repeat retirement lands in the 20th RUN cycle -> done_code=01, not 10.
REQ-038 Bench SHALL check: restart pulse while HALTED -> done=0, counters=0, cpu_reset=1 for 4 cycles, then RUN, and the loop detector does not match the stale last_pc.
REQ-039 Bench SHALL check: reset and restart asserted together mid-RUN, and retire_valid during HOLD -> reset behaviour per REQ-030, and instr_cnt stays 0 until RUN.
